// File: rtl/ccu_axil_master_pkg.sv
// Shared definitions for the CCU AXI-Lite command master: control-register
// map, command opcodes, FSM states and AXI response codes.
package ccu_axil_master_pkg;

  localparam int CTLR_ADDR = 12;

  localparam logic [CTLR_ADDR-1:0] REG_OPER_GO  = 12'h000;
  localparam logic [CTLR_ADDR-1:0] REG_LOAD_FLG = 12'h004;
  localparam logic [CTLR_ADDR-1:0] REG_DATA_LEN = 12'h010;
  localparam logic [CTLR_ADDR-1:0] REG_OPER_STS = 12'h020;
  localparam logic [CTLR_ADDR-1:0] REG_OPER_DNE = 12'h024;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WR_B  = 3'd2,
    ST_RD_AR = 3'd3,
    ST_RD_R  = 3'd4,
    ST_GAP   = 3'd5,
    ST_RSP   = 3'd6
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Address-independent part of a latched command.
  typedef struct packed {
    cmd_op_e     op;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] mask;
    logic [31:0] match;
  } cmd_t;

  function automatic logic poll_hit(input logic [31:0] data,
                                    input logic [31:0] mask,
                                    input logic [31:0] match);
    return ((data ^ match) & mask) == 32'h0;
  endfunction

endpackage

// File: rtl/ccu_axil_master_if.sv
// Single AXI-Lite bus between the command master and the CCU register file.
interface ccu_axil_master_if
  import ccu_axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH = CTLR_ADDR
) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/ccu_axil_master.sv
// Command/response to AXI-Lite master for the CCU control registers, with a
// built-in masked poll that repeats reads until match, error or timeout.
module ccu_axil_master
  import ccu_axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH = CTLR_ADDR,
  parameter int POLL_GAP   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  input  logic [3:0]            cmd_wstrb_i,
  input  logic [31:0]           cmd_mask_i,
  input  logic [31:0]           cmd_match_i,
  input  logic [CNT_WIDTH-1:0]  cmd_timeout_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  output logic                  rsp_timeout_o,
  output logic [CNT_WIDTH-1:0]  rsp_polls_o,
  output logic                  busy_o,
  ccu_axil_master_if.master     m_axil
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  state_e                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  to_q, to_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    to_d      = to_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d.op    = (cmd_op_e'(cmd_op_i) == OP_RSVD) ? OP_READ : cmd_op_e'(cmd_op_i);
          cmd_d.wdata = cmd_wdata_i;
          cmd_d.wstrb = cmd_wstrb_i;
          cmd_d.mask  = cmd_mask_i;
          cmd_d.match = cmd_match_i;
          addr_d      = cmd_addr_i;
          tmo_d       = cmd_timeout_i;
          cnt_d       = '0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          rdata_d     = '0;
          resp_d      = RESP_OKAY;
          to_d        = 1'b0;
          state_d     = (cmd_d.op == OP_WRITE) ? ST_WR : ST_RD_AR;
        end
      end
      ST_WR: begin
        // AW and W retire independently; B waits for both.
        if (awvalid_q && m_axil.awready) aw_done_d = 1'b1;
        if (wvalid_q && m_axil.wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)       state_d   = ST_WR_B;
      end
      ST_WR_B: begin
        if (m_axil.bvalid) begin
          resp_d  = m_axil.bresp;
          state_d = ST_RSP;
        end
      end
      ST_RD_AR: begin
        if (m_axil.arready) state_d = ST_RD_R;
      end
      ST_RD_R: begin
        if (m_axil.rvalid) begin
          rdata_d = m_axil.rdata;
          resp_d  = m_axil.rresp;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          if (cmd_q.op != OP_POLL || m_axil.rresp != RESP_OKAY ||
              poll_hit(m_axil.rdata, cmd_q.mask, cmd_q.match)) begin
            state_d = ST_RSP;
          end else if (tmo_q != '0 && cnt_d == tmo_q) begin
            to_d    = 1'b1;
            state_d = ST_RSP;
          end else begin
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_RD_AR;
        else                   gap_d   = gap_q + 1'b1;
      end
      ST_RSP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Channel controls are registered copies of the next-state decode.
    awvalid_d = (state_d == ST_WR) && !aw_done_d;
    wvalid_d  = (state_d == ST_WR) && !w_done_d;
    bready_d  = (state_d == ST_WR_B);
    arvalid_d = (state_d == ST_RD_AR);
    rready_d  = (state_d == ST_RD_R);
  end

  assign cmd_ready_o   = rst_n_i && (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign rsp_valid_o   = (state_q == ST_RSP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_resp_o    = resp_q;
  assign rsp_timeout_o = to_q;
  assign rsp_polls_o   = cnt_q;

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = cmd_q.wdata;
  assign m_axil.wstrb   = cmd_q.wstrb;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

endmodule
